// File: rtl/io_pkg.sv
// Shared definitions for the MMIO peripheral: bus widths, register offsets and
// the active-low hex-to-seven-segment decoder.
package io_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIGITS = 8;

    // Register offsets within the 1 KiB I/O window (word aligned)
    localparam logic [ADDR_W-1:0] IO_SW   = 10'h000;
    localparam logic [ADDR_W-1:0] IO_BTN  = 10'h004;
    localparam logic [ADDR_W-1:0] IO_LED  = 10'h010;
    localparam logic [ADDR_W-1:0] IO_SEGD = 10'h020;
    localparam logic [ADDR_W-1:0] IO_SEGE = 10'h024;

    // Hex nibble to segments {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmio_periph_if.sv
// I/O bus between the control unit (master) and the MMIO peripheral (slave).
//   io_read/io_write : access strobes
//   addr             : offset within the I/O window
//   wdata            : store data
//   rdata            : read data, same cycle as io_read
interface mmio_periph_if;
    import io_pkg::*;

    logic              io_read;
    logic              io_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output io_read, output io_write, output addr, output wdata, input rdata);
    modport slave  (input io_read, input io_write, input addr, input wdata, output rdata);

endinterface

// File: rtl/io_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
//   clk, rst_n : clock, async active-low reset
//   i_raw      : asynchronous input
//   o_level    : debounced level (registered)
//   o_rise_c   : combinational, high in the cycle whose edge raises o_level
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_done;

    // Counter only runs while a change is pending; any return to the current level restarts it
    assign w_done = (r_sync != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise_c = w_done && r_sync;

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped I/O slave: switches, debounced button, LEDs and a scanned
// 8-digit seven-segment display.
//   clk, rst_n : clock, async active-low reset
//   bus        : I/O bus slave (io_read, io_write, addr, wdata -> rdata)
//   sw_raw     : asynchronous switches
//   btn_raw    : asynchronous confirm button, active-high
//   led        : LED drive
//   seg_an     : digit enables, active-low
//   seg_cat    : {dp,g..a}, active-low
module mmio_periph
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 200000,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned SW_W         = 16,
    parameter int unsigned LED_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_periph_if.slave      bus,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic              btn_raw,
    output logic [LED_W-1:0]  led,
    output logic [7:0]        seg_an,
    output logic [7:0]        seg_cat
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW_W-1:0]     r_sw_meta;
    logic [SW_W-1:0]     r_sw_sync;
    logic [LED_W-1:0]    r_led;
    logic [DATA_W-1:0]   r_segd;
    logic [DIGITS-1:0]   r_sege;
    logic                r_btn_pressed;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [2:0]          r_digit;
    logic [7:0]          r_seg_an;
    logic [7:0]          r_seg_cat;

    logic [ADDR_W-1:0]   w_off;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_wr_led;
    logic                w_wr_segd;
    logic                w_wr_sege;
    logic                w_rd_btn;
    logic                w_btn_level;
    logic                w_btn_rise;
    logic [3:0]          w_nib;
    logic                w_unused_addr;

    // Byte offset bits are ignored; only word selects matter
    assign w_off         = {bus.addr[ADDR_W-1:2], 2'b00};
    assign w_unused_addr = ^bus.addr[1:0];

    assign w_wr_led  = bus.io_write && (w_off == IO_LED);
    assign w_wr_segd = bus.io_write && (w_off == IO_SEGD);
    assign w_wr_sege = bus.io_write && (w_off == IO_SEGE);
    assign w_rd_btn  = bus.io_read  && (w_off == IO_BTN);

    io_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (btn_raw),
        .o_level  (w_btn_level),
        .o_rise_c (w_btn_rise)
    );

    // Read mux: pre-write register contents, zero when idle or unmapped
    always_comb begin
        w_rdata = '0;
        if (bus.io_read) begin
            case (w_off)
                IO_SW:   w_rdata = DATA_W'(r_sw_sync);
                IO_BTN:  w_rdata = DATA_W'({r_btn_pressed, w_btn_level});
                IO_LED:  w_rdata = DATA_W'(r_led);
                IO_SEGD: w_rdata = r_segd;
                IO_SEGE: w_rdata = DATA_W'(r_sege);
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;

    // Switch synchroniser and writable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_led     <= '0;
            r_segd    <= '0;
            r_sege    <= '0;
        end else begin
            r_sw_meta <= sw_raw;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led)  r_led  <= bus.wdata[LED_W-1:0];
            if (w_wr_segd) r_segd <= bus.wdata;
            if (w_wr_sege) r_sege <= bus.wdata[DIGITS-1:0];
        end
    end

    // Sticky press flag: a new press beats a simultaneous read-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_pressed <= 1'b0;
        end else if (w_btn_rise) begin
            r_btn_pressed <= 1'b1;
        end else if (w_rd_btn) begin
            r_btn_pressed <= 1'b0;
        end
    end

    assign w_nib = r_segd[{r_digit, 2'b00} +: 4];

    // Display scan; outputs are registered from the current index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_seg_an   <= 8'hFF;
            r_seg_cat  <= 8'hFF;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            r_seg_an  <= ~(8'b1 << r_digit);
            r_seg_cat <= r_sege[r_digit] ? {1'b1, hex_to_seg(w_nib)} : 8'hFF;
        end
    end

    assign led     = r_led;
    assign seg_an  = r_seg_an;
    assign seg_cat = r_seg_cat;

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph: register-access vector table,
// hand-written button/scan/reset sequences and a randomized run against a
// behavioural model.
module tb_mmio_periph;

    localparam int unsigned DEB   = 4;
    localparam int unsigned SDIV  = 3;
    localparam int unsigned SW_W  = 16;
    localparam int unsigned LED_W = 16;

    localparam logic [9:0] A_SW   = 10'h000;
    localparam logic [9:0] A_BTN  = 10'h004;
    localparam logic [9:0] A_LED  = 10'h010;
    localparam logic [9:0] A_SEGD = 10'h020;
    localparam logic [9:0] A_SEGE = 10'h024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SW_W-1:0]   sw_raw;
    logic              btn_raw;
    logic [LED_W-1:0]  led;
    logic [7:0]        seg_an;
    logic [7:0]        seg_cat;

    int n_pass  = 0;
    int n_total = 0;
    int unsigned ecnt;

    // Common-anode patterns {dp,g..a}, dp off
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    mmio_periph_if bus ();

    mmio_periph #(
        .DEBOUNCE_CYC (DEB),
        .SCAN_DIV     (SDIV),
        .SW_W         (SW_W),
        .LED_W        (LED_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sw_raw  (sw_raw),
        .btn_raw (btn_raw),
        .led     (led),
        .seg_an  (seg_an),
        .seg_cat (seg_cat)
    );

    // Clock edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
        bus.io_read  = rd;
        bus.io_write = wr;
        bus.addr     = a;
        bus.wdata    = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 10'h0, 32'h0);
        sw_raw  = '0;
        btn_raw = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Expected display outputs after n edges since reset
    function automatic logic [7:0] exp_an(input int unsigned n);
        int unsigned idx;
        if (n == 0) return 8'hFF;
        idx = ((n - 1) / SDIV) % 8;
        return ~(8'(1) << idx);
    endfunction

    function automatic logic [7:0] exp_cat(input int unsigned n, input logic [31:0] segd, input logic [7:0] sege);
        int unsigned idx;
        logic [3:0] nib;
        if (n == 0) return 8'hFF;
        idx = ((n - 1) / SDIV) % 8;
        nib = 4'((segd >> (4 * idx)) & 32'hF);
        return sege[idx] ? seg_tab[nib] : 8'hFF;
    endfunction

    initial begin
        // ---- reset state ----
        rst_n   = 1'b0;
        sw_raw  = '0;
        btn_raw = 1'b0;
        drive(1'b0, 1'b0, 10'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("reset led", 32'(led), 32'h0);
        check("reset seg_an", 32'(seg_an), 32'hFF);
        check("reset seg_cat", 32'(seg_cat), 32'hFF);
        check("reset rdata", bus.rdata, 32'h0);
        #2 rst_n = 1'b1;

        // ---- register access vector table ----
        vecs[0]  = '{1'b1, 1'b0, A_LED,   32'h0,         32'h0,         16'h0};
        vecs[1]  = '{1'b0, 1'b1, A_LED,   32'h1234_FFFF, 32'h0,         16'h0};
        vecs[2]  = '{1'b1, 1'b0, A_LED,   32'h0,         32'h0000_FFFF, 16'hFFFF};
        vecs[3]  = '{1'b0, 1'b1, 10'h3FC, 32'hDEAD_BEEF, 32'h0,         16'hFFFF};
        vecs[4]  = '{1'b1, 1'b0, 10'h3FC, 32'h0,         32'h0,         16'hFFFF};
        vecs[5]  = '{1'b1, 1'b1, A_LED,   32'h0000_0055, 32'h0000_FFFF, 16'hFFFF};
        vecs[6]  = '{1'b1, 1'b0, A_LED,   32'h0,         32'h0000_0055, 16'h0055};
        vecs[7]  = '{1'b0, 1'b1, 10'h013, 32'h0000_A5A5, 32'h0,         16'h0055};
        vecs[8]  = '{1'b1, 1'b0, 10'h012, 32'h0,         32'h0000_A5A5, 16'hA5A5};
        vecs[9]  = '{1'b0, 1'b1, A_SEGE,  32'h0000_01FF, 32'h0,         16'hA5A5};
        vecs[10] = '{1'b1, 1'b0, A_SEGE,  32'h0,         32'h0000_00FF, 16'hA5A5};
        vecs[11] = '{1'b0, 1'b1, A_SEGD,  32'h89AB_CDEF, 32'h0,         16'hA5A5};
        vecs[12] = '{1'b1, 1'b0, 10'h022, 32'h0,         32'h89AB_CDEF, 16'hA5A5};
        vecs[13] = '{1'b1, 1'b0, 10'h008, 32'h0,         32'h0,         16'hA5A5};
        vecs[14] = '{1'b1, 1'b1, A_SEGE,  32'h0,         32'h0000_00FF, 16'hA5A5};
        vecs[15] = '{1'b1, 1'b0, A_SEGE,  32'h0,         32'h0,         16'hA5A5};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].exp_led));
        end

        // ---- switch synchroniser latency ----
        @(negedge clk);
        sw_raw = 16'hA5C3;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            drive(1'b1, 1'b0, A_SW, 32'h0);
            #1;
            check($sformatf("sw cyc%0d", i), bus.rdata, (i >= 2) ? 32'h0000_A5C3 : 32'h0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, A_SW, 32'h0);
        #1 check("sw idle rdata", bus.rdata, 32'h0);

        // ---- button: bounce rejected, then stable press ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_raw = ((i % 4) < 2);
            drive(1'b1, 1'b0, A_BTN, 32'h0);
            #1 check($sformatf("bounce %0d", i), bus.rdata, 32'h0);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            btn_raw = 1'b1;
            drive(1'b1, 1'b0, A_BTN, 32'h0);
            #1 check($sformatf("hold %0d", i), bus.rdata, (i == 6) ? 32'd3 : ((i > 6) ? 32'd1 : 32'd0));
        end
        // Release long enough for the level to fall
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_raw = 1'b0;
            drive(1'b0, 1'b0, 10'h0, 32'h0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, A_BTN, 32'h0);
        #1 check("released", bus.rdata, 32'd0);
        // Second press: read lands on the same edge that sets the flag
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_raw = 1'b1;
            if (i >= 5) begin
                drive(1'b1, 1'b0, A_BTN, 32'h0);
                #1 check($sformatf("press vs read %0d", i), bus.rdata,
                         (i == 5) ? 32'd0 : ((i == 6) ? 32'd3 : 32'd1));
            end else begin
                drive(1'b0, 1'b0, 10'h0, 32'h0);
            end
        end

        // ---- randomized run against behavioural model ----
        begin
            logic [9:0]  alist [8] = '{10'h000, 10'h004, 10'h010, 10'h020, 10'h024, 10'h3FC, 10'h008, 10'h011};
            logic [15:0] m_led = '0;
            logic [31:0] m_segd = '0;
            logic [7:0]  m_sege = '0;
            logic [15:0] sw_h1 = '0, sw_h2 = '0;
            logic        bt_h1 = 1'b0, bt_h2 = 1'b0;
            logic        m_level = 1'b0, m_pressed = 1'b0, rise;
            int          m_run = 0;
            int          hold = 0;
            logic        rd, wr;
            logic [9:0]  a, off;
            logic [31:0] d, exp;

            do_reset();
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                rd = 1'($urandom % 2);
                wr = ($urandom % 4) == 0;
                a  = alist[$urandom_range(0, 7)];
                d  = $urandom;
                sw_raw = 16'($urandom);
                if (hold == 0) begin
                    btn_raw = 1'($urandom % 2);
                    hold    = $urandom_range(1, 9);
                end else begin
                    hold--;
                end
                drive(rd, wr, a, d);
                #1;
                off = a & 10'h3FC;
                exp = 32'h0;
                if (rd) begin
                    if (off == A_SW)        exp = {16'h0, sw_h2};
                    else if (off == A_BTN)  exp = {30'h0, m_pressed, m_level};
                    else if (off == A_LED)  exp = {16'h0, m_led};
                    else if (off == A_SEGD) exp = m_segd;
                    else if (off == A_SEGE) exp = {24'h0, m_sege};
                end
                check($sformatf("rand%0d rdata a=%h", t, a), bus.rdata, exp);
                check($sformatf("rand%0d led", t), 32'(led), 32'(m_led));
                // Level follows the synchronised input once it has differed for DEB edges
                rise = 1'b0;
                if (bt_h2 != m_level) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_level = bt_h2;
                        m_run   = 0;
                        rise    = bt_h2;
                    end
                end else begin
                    m_run = 0;
                end
                if (rise) m_pressed = 1'b1;
                else if (rd && off == A_BTN) m_pressed = 1'b0;
                if (wr && off == A_LED)  m_led  = d[15:0];
                if (wr && off == A_SEGD) m_segd = d;
                if (wr && off == A_SEGE) m_sege = d[7:0];
                sw_h2 = sw_h1; sw_h1 = sw_raw;
                bt_h2 = bt_h1; bt_h1 = btn_raw;
            end
        end

        // ---- display scan with live SEGD update, then reset mid-scan ----
        begin
            logic [31:0] segd_cur = '0, segd_prev = '0;
            logic [7:0]  sege_cur = '0, sege_prev = '0;
            do_reset();
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                drive(1'b0, 1'b0, 10'h0, 32'h0);
                #1;
                check($sformatf("scan%0d an", i), 32'(seg_an), 32'(exp_an(ecnt)));
                check($sformatf("scan%0d cat", i), 32'(seg_cat), 32'(exp_cat(ecnt, segd_prev, sege_prev)));
                segd_prev = segd_cur;
                sege_prev = sege_cur;
                if (i == 0)  begin drive(1'b0, 1'b1, A_SEGD, 32'h0000_00F1); segd_cur = 32'h0000_00F1; end
                if (i == 1)  begin drive(1'b0, 1'b1, A_SEGE, 32'h0000_0003); sege_cur = 8'h03; end
                if (i == 2)  drive(1'b0, 1'b1, A_LED, 32'h0000_BEEF);
                if (i == 40) begin drive(1'b0, 1'b1, A_SEGD, 32'h0000_00F2); segd_cur = 32'h0000_00F2; end
            end
            check("led before reset", 32'(led), 32'h0000_BEEF);
            @(negedge clk);
            drive(1'b0, 1'b0, 10'h0, 32'h0);
            #2 rst_n = 1'b0;
            #1;
            check("midrst led", 32'(led), 32'h0);
            check("midrst seg_an", 32'(seg_an), 32'hFF);
            check("midrst seg_cat", 32'(seg_cat), 32'hFF);
            @(negedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            drive(1'b1, 1'b0, A_LED, 32'h0);
            #1 check("post-reset LED read", bus.rdata, 32'h0);
            @(negedge clk);
            drive(1'b1, 1'b0, A_SEGD, 32'h0);
            #1 check("post-reset SEGD read", bus.rdata, 32'h0);
            @(negedge clk);
            drive(1'b0, 1'b0, 10'h0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
